bash_f_sched: RTL and testbench

Round scheduler for the bash-f permutation. It accepts a 1536-bit state through a valid/ready handshake and drives an external single-round bash_f_stage instance for ROUNDS rounds. It generates the 64-bit round constant itself and stores the state between rounds. It returns the permuted state through a valid/ready handshake, and sits between the sponge/absorb logic and the round datapath.

---
 rtl/bash_f_sched_if.sv | 27 ++
 rtl/bash_f_sched.sv | 112 +++++++++++
 tb/tb_bash_f_sched.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bash_f_sched_if.sv
// Handshake and round-stage bundle between bash_f_sched and its neighbours.
// master = scheduler side; slave = sponge producer/consumer plus round stage.
interface bash_f_sched_if;
  logic          in_valid;
  logic          in_ready;
  logic [1535:0] data_i;
  logic          abort;
  logic [1535:0] stage_data_o;
  logic [63:0]   stage_c_o;
  logic          stage_vld_o;
  logic [1535:0] stage_data_i;
  logic          out_valid;
  logic          out_ready;
  logic [1535:0] data_o;
  logic          busy;
  logic [4:0]    round_o;

  modport master (
    input  in_valid, data_i, abort, stage_data_i, out_ready,
    output in_ready, stage_data_o, stage_c_o, stage_vld_o, out_valid, data_o, busy, round_o
  );

  modport slave (
    output in_valid, data_i, abort, stage_data_i, out_ready,
    input  in_ready, stage_data_o, stage_c_o, stage_vld_o, out_valid, data_o, busy, round_o
  );
endinterface

// File: rtl/bash_f_sched.sv
// bash-f round scheduler: ROUNDS*STAGE_LAT cycles accept-to-out_valid, one job in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready (abort wins).
module bash_f_sched #(
  parameter int          ROUNDS    = 24,
  parameter int          STAGE_LAT = 1,
  parameter logic [63:0] C_INIT    = 64'hB194BAC80A08F53B,
  parameter logic [63:0] C_POLY    = 64'hDC2BE1997FE0D8AE
) (
  input  logic              clk,
  input  logic              rst,
  bash_f_sched_if.master    bus
);

  localparam int LW = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [1535:0]   s;
  logic [63:0]     c;
  logic [63:0]     c_nxt;
  logic [4:0]      round;
  logic [LW-1:0]   lat_cnt;
  logic            lat_last;
  logic            last_round;
  logic            load;
  logic            step;
  logic            clr;

  assign lat_last   = (lat_cnt == LW'(STAGE_LAT - 1));
  assign last_round = (round == 5'(ROUNDS - 1));
  assign c_nxt      = (c >> 1) ^ (c[0] ? C_POLY : 64'h0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    load             = 1'b0;
    step             = 1'b0;
    clr              = 1'b0;
    bus.in_ready     = 1'b0;
    bus.out_valid    = 1'b0;
    bus.busy         = 1'b0;
    bus.stage_vld_o  = 1'b0;
    bus.data_o       = s;
    bus.stage_data_o = s;
    bus.stage_c_o    = c;
    bus.round_o      = round;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        bus.busy        = 1'b1;
        bus.stage_vld_o = (lat_cnt == '0);
        if (bus.abort) begin
          clr       = 1'b1;
          state_nxt = IDLE;
        end else if (lat_last) begin
          step = 1'b1;
          if (last_round) state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        // abort takes precedence so a cancelled result is never handed over
        if (bus.abort) begin
          clr       = 1'b1;
          state_nxt = IDLE;
        end else if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s       <= '0;
      c       <= C_INIT;
      round   <= '0;
      lat_cnt <= '0;
    end else if (load) begin
      s       <= bus.data_i;
      c       <= C_INIT;
      round   <= '0;
      lat_cnt <= '0;
    end else if (clr) begin
      round   <= '0;
      lat_cnt <= '0;
    end else if (step) begin
      s       <= bus.stage_data_i;
      c       <= c_nxt;
      lat_cnt <= '0;
      if (!last_round) round <= round + 5'd1;
    end else if (state == RUN) begin
      lat_cnt <= lat_cnt + LW'(1);
    end
  end

endmodule

// File: tb/tb_bash_f_sched.sv
// Bench for bash_f_sched: single-cycle and 3-cycle round stage models (x ^ replicated C),
// scoreboard queues for results, direct checks for constants, timing, abort and reset.
module tb_bash_f_sched;

  typedef logic [1535:0] w_t;

  localparam logic [63:0] C_INIT = 64'hB194BAC80A08F53B;
  localparam logic [63:0] C_POLY = 64'hDC2BE1997FE0D8AE;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bash_f_sched_if a_if ();
  bash_f_sched_if b_if ();

  bash_f_sched #(.STAGE_LAT(1)) u_a (.clk(clk), .rst(rst_a), .bus(a_if));
  bash_f_sched #(.STAGE_LAT(3)) u_b (.clk(clk), .rst(rst_b), .bus(b_if));

  assign a_if.stage_data_i = a_if.stage_data_o ^ {24{a_if.stage_c_o}};
  assign b_if.stage_data_i = b_if.stage_data_o ^ {24{b_if.stage_c_o}};

  function automatic logic [63:0] fold(input w_t v);
    logic [63:0] f = '0;
    for (int i = 0; i < 24; i++) f ^= v[i*64 +: 64];
    return f;
  endfunction

  task automatic check(input string tag, input w_t act, input w_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got(fold)=%h want(fold)=%h", tag, fold(act), fold(exp));
    end
  endtask

  function automatic logic [63:0] cnext(input logic [63:0] c);
    return (c >> 1) ^ (c[0] ? C_POLY : 64'h0);
  endfunction

  function automatic w_t perm(input w_t x);
    w_t          v = x;
    logic [63:0] c = C_INIT;
    for (int r = 0; r < 24; r++) begin
      v = v ^ {24{c}};
      c = cnext(c);
    end
    return v;
  endfunction

  function automatic w_t rnd();
    w_t v;
    for (int i = 0; i < 48; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  w_t a_q[$];
  w_t b_q[$];
  int a_hs = 0;
  int b_hs = 0;
  int a_hs_edge = -1;
  int a_acc = 0;

  always @(negedge clk) begin
    if (rst_a && a_if.out_valid && a_if.out_ready && !a_if.abort) begin
      a_hs++;
      a_hs_edge = cyc + 1;
      if (a_q.size() == 0) check("a_sb_empty", w_t'(0), w_t'(1));
      else check("a_sb_data", a_if.data_o, a_q.pop_front());
    end
    if (rst_b && b_if.out_valid && b_if.out_ready && !b_if.abort) begin
      b_hs++;
      if (b_q.size() == 0) check("b_sb_empty", w_t'(0), w_t'(1));
      else check("b_sb_data", b_if.data_o, b_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input w_t d, input bit keep);
    int n = 0;
    a_if.data_i   = d;
    a_if.in_valid = 1'b1;
    while (!a_if.in_ready && n < 200) begin
      tick();
      n++;
    end
    check("a_accept_timeout", w_t'(a_if.in_ready), w_t'(1));
    a_q.push_back(perm(d));
    a_acc = cyc + 1;
    tick();
    if (!keep) a_if.in_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (a_hs < target && n < 200) begin
      tick();
      n++;
    end
    check("a_hs_count", w_t'(a_hs), w_t'(target));
  endtask

  initial begin
    logic [63:0] cm;
    w_t          d;
    w_t          e;
    int          hs0;
    int          n;
    int          pulses;
    int          badgap;
    int          last_p;
    int          b_acc;

    a_if.in_valid = 1'b0; a_if.data_i = '0; a_if.abort = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.data_i = '0; b_if.abort = 1'b0; b_if.out_ready = 1'b1;
    repeat (3) tick();

    check("rst_in_ready", w_t'(a_if.in_ready), w_t'(1));
    check("rst_out_valid", w_t'(a_if.out_valid), w_t'(0));
    check("rst_busy", w_t'(a_if.busy), w_t'(0));
    check("rst_stage_vld", w_t'(a_if.stage_vld_o), w_t'(0));
    check("rst_c", w_t'(a_if.stage_c_o), w_t'(C_INIT));
    check("rst_round", w_t'(a_if.round_o), w_t'(0));
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();

    // job 1: constants, round index, exact latency, output hold
    d = rnd();
    e = perm(d);
    send_a(d, 1'b0);
    check("busy_run", w_t'(a_if.busy), w_t'(1));
    check("in_ready_run", w_t'(a_if.in_ready), w_t'(0));
    cm = C_INIT;
    for (int r = 0; r < 24; r++) begin
      check($sformatf("round_%0d", r), w_t'(a_if.round_o), w_t'(r));
      check($sformatf("c_%0d", r), w_t'(a_if.stage_c_o), w_t'(cm));
      check($sformatf("vld_%0d", r), w_t'(a_if.stage_vld_o), w_t'(1));
      check($sformatf("ov_early_%0d", r), w_t'(a_if.out_valid), w_t'(0));
      cm = cnext(cm);
      tick();
    end
    check("c1_literal", w_t'(64'h84E1BCFD7AE4A233), w_t'(cnext(C_INIT)));
    check("latency", w_t'(cyc - a_acc), w_t'(24));
    check("ov_done", w_t'(a_if.out_valid), w_t'(1));
    check("stage_vld_done", w_t'(a_if.stage_vld_o), w_t'(0));
    repeat (5) tick();
    check("hold_out_valid", w_t'(a_if.out_valid), w_t'(1));
    check("hold_data", a_if.data_o, e);
    check("hold_in_ready", w_t'(a_if.in_ready), w_t'(0));
    a_if.out_ready = 1'b1;
    tick();
    check("after_hs_idle", w_t'(a_if.in_ready), w_t'(1));
    check("after_hs_ov", w_t'(a_if.out_valid), w_t'(0));
    check("hs1", w_t'(a_hs), w_t'(1));

    // back-to-back with in_valid held high
    send_a(rnd(), 1'b1);
    send_a(rnd(), 1'b0);
    check("b2b_gap", w_t'(a_acc - a_hs_edge), w_t'(1));
    wait_hs(3);

    // abort at round 10
    send_a(rnd(), 1'b0);
    repeat (10) tick();
    check("abort_round", w_t'(a_if.round_o), w_t'(10));
    a_if.abort = 1'b1;
    tick();
    a_if.abort = 1'b0;
    void'(a_q.pop_back());
    check("abort_idle", w_t'(a_if.in_ready), w_t'(1));
    check("abort_busy", w_t'(a_if.busy), w_t'(0));
    check("abort_round0", w_t'(a_if.round_o), w_t'(0));
    hs0 = a_hs;
    repeat (30) tick();
    check("abort_no_out", w_t'(a_hs), w_t'(hs0));

    // abort in IDLE is ignored
    a_if.abort = 1'b1;
    tick();
    a_if.abort = 1'b0;
    check("idle_abort_ready", w_t'(a_if.in_ready), w_t'(1));
    check("idle_abort_busy", w_t'(a_if.busy), w_t'(0));

    // asynchronous reset at round 5
    send_a(rnd(), 1'b0);
    repeat (5) tick();
    check("rst_mid_round", w_t'(a_if.round_o), w_t'(5));
    rst_a = 1'b0;
    #1;
    void'(a_q.pop_back());
    check("rst_mid_busy", w_t'(a_if.busy), w_t'(0));
    check("rst_mid_ready", w_t'(a_if.in_ready), w_t'(1));
    check("rst_mid_c", w_t'(a_if.stage_c_o), w_t'(C_INIT));
    tick();
    rst_a = 1'b1;
    hs0 = a_hs;
    repeat (30) tick();
    check("rst_no_out", w_t'(a_hs), w_t'(hs0));
    send_a(rnd(), 1'b0);
    wait_hs(hs0 + 1);

    // abort and out_ready together in DONE
    a_if.out_ready = 1'b0;
    send_a(rnd(), 1'b0);
    n = 0;
    while (!a_if.out_valid && n < 200) begin
      tick();
      n++;
    end
    check("done_reach", w_t'(a_if.out_valid), w_t'(1));
    hs0 = a_hs;
    a_if.out_ready = 1'b1;
    a_if.abort = 1'b1;
    tick();
    a_if.abort = 1'b0;
    void'(a_q.pop_back());
    check("abort_done_ov", w_t'(a_if.out_valid), w_t'(0));
    check("abort_done_idle", w_t'(a_if.in_ready), w_t'(1));
    check("abort_done_no_hs", w_t'(a_hs), w_t'(hs0));

    // STAGE_LAT = 3 instance
    d = rnd();
    b_if.data_i = d;
    b_if.in_valid = 1'b1;
    check("b_ready", w_t'(b_if.in_ready), w_t'(1));
    b_q.push_back(perm(d));
    b_acc = cyc + 1;
    tick();
    b_if.in_valid = 1'b0;
    pulses = 0; badgap = 0; last_p = -1; n = 0;
    while (!b_if.out_valid && n < 200) begin
      if (b_if.stage_vld_o) begin
        pulses++;
        if (last_p >= 0 && cyc - last_p != 3) badgap++;
        last_p = cyc;
      end
      tick();
      n++;
    end
    check("b_pulses", w_t'(pulses), w_t'(24));
    check("b_gaps", w_t'(badgap), w_t'(0));
    check("b_latency", w_t'(cyc - b_acc), w_t'(72));
    tick();
    check("b_hs", w_t'(b_hs), w_t'(1));
    check("a_q_empty", w_t'(a_q.size()), w_t'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
